// File: rtl/exec_mem_unit.sv
// exec_mem_unit: execute/memory cluster of the 16-bit pipeline.
// Program counter with redirect, registered ALU with branch/jump
// resolution, and a word-addressed data memory with registered reads.
// Optional multiplier (opcode 0x0C) enabled by defining ALU_MULT_EN.
module exec_mem_unit #(
  parameter int DATA_W    = 16,
  parameter int PC_W      = 16,
  parameter int TGT_W     = 12,
  parameter int MEM_DEPTH = 256,
  parameter int RA_W      = 3
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic [7:0]        alu_op_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic [RA_W-1:0]   dst_i,
  input  logic              haz_i,
  input  logic [TGT_W-1:0]  cnt_i,
  input  logic              mem_wr_en_i,
  input  logic              mem_rd_en_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [RA_W-1:0]   mem_dst_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] alu_res_o,
  output logic              alu_we_o,
  output logic [RA_W-1:0]   alu_dst_o,
  output logic              haz_o,
  output logic [PC_W-1:0]   cnt_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_we_o,
  output logic [RA_W-1:0]   mem_dst_o
);
  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_AND = 8'h03,
                         OP_OR  = 8'h04, OP_XOR = 8'h05, OP_SLL = 8'h06,
                         OP_SRL = 8'h07, OP_SLT = 8'h08, OP_BEQ = 8'h09,
                         OP_BNE = 8'h0A, OP_JMP = 8'h0B, OP_MUL = 8'h0C;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] alu_res_q, alu_res_d;
  logic              alu_we_q, alu_we_d;
  logic [RA_W-1:0]   alu_dst_q, alu_dst_d;
  logic              haz_q, haz_d;
  logic [PC_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q;
  logic              mwe_q;
  logic [RA_W-1:0]   mdst_q;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [AW-1:0] waddr;
  logic          unused_addr;
  logic          taken;

  // Only the low address bits select a word; higher bits alias.
  assign waddr       = mem_addr_i[AW-1:0];
  assign unused_addr = ^mem_addr_i[DATA_W-1:AW];

  // Next-state for PC, ALU result and branch resolution.
  always_comb begin
    pc_d      = haz_q ? cnt_q : pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    alu_res_d = alu_res_q;
    alu_dst_d = alu_dst_q;
    alu_we_d  = 1'b1;
    taken     = 1'b0;
    unique case (alu_op_i)
      OP_ADD:  alu_res_d = op_a_i + op_b_i;
      OP_SUB:  alu_res_d = op_a_i - op_b_i;
      OP_AND:  alu_res_d = op_a_i & op_b_i;
      OP_OR:   alu_res_d = op_a_i | op_b_i;
      OP_XOR:  alu_res_d = op_a_i ^ op_b_i;
      OP_SLL:  alu_res_d = op_a_i << op_b_i[3:0];
      OP_SRL:  alu_res_d = op_a_i >> op_b_i[3:0];
      OP_SLT:  alu_res_d = {{(DATA_W-1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
`ifdef ALU_MULT_EN
      OP_MUL:  alu_res_d = op_a_i * op_b_i;
`endif
      OP_BEQ:  begin alu_we_d = 1'b0; taken = (op_a_i == op_b_i); end
      OP_BNE:  begin alu_we_d = 1'b0; taken = (op_a_i != op_b_i); end
      OP_JMP:  begin alu_we_d = 1'b0; taken = 1'b1; end
      default: alu_we_d = 1'b0;
    endcase
    if (alu_we_d) alu_dst_d = dst_i;
    // Decode must qualify control transfers, otherwise they are ignored.
    haz_d = haz_i & taken;
    cnt_d = haz_d ? {{(PC_W-TGT_W){1'b0}}, cnt_i} : cnt_q;
  end

  // Pipeline registers for PC, ALU and redirect.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      pc_q      <= '0;
      alu_res_q <= '0;
      alu_we_q  <= 1'b0;
      alu_dst_q <= '0;
      haz_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      alu_res_q <= alu_res_d;
      alu_we_q  <= alu_we_d;
      alu_dst_q <= alu_dst_d;
      haz_q     <= haz_d;
      cnt_q     <= cnt_d;
    end
  end

  // Data memory: whole array cleared on reset, reads see the pre-write word.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
      mwe_q   <= 1'b0;
      mdst_q  <= '0;
    end else begin
      if (mem_wr_en_i) mem_q[waddr] <= mem_wdata_i;
      if (mem_rd_en_i) begin
        rdata_q <= mem_q[waddr];
        mdst_q  <= mem_dst_i;
      end
      mwe_q <= mem_rd_en_i;
    end
  end

  assign pc_o        = pc_q;
  assign alu_res_o   = alu_res_q;
  assign alu_we_o    = alu_we_q;
  assign alu_dst_o   = alu_dst_q;
  assign haz_o       = haz_q;
  assign cnt_o       = cnt_q;
  assign mem_rdata_o = rdata_q;
  assign mem_we_o    = mwe_q;
  assign mem_dst_o   = mdst_q;
endmodule

// File: tb/tb_exec_mem_unit.sv
// Testbench for exec_mem_unit: directed steps plus random traffic,
// compared every cycle against a behavioural model of the spec rules.
module tb_exec_mem_unit;
  logic        clk = 0;
  logic        rst;
  logic [7:0]  op;
  logic [15:0] a, b;
  logic [2:0]  dst;
  logic        hz;
  logic [11:0] tgt;
  logic        wr, rd;
  logic [15:0] addr, wdata;
  logic [2:0]  mdst;
  logic [15:0] pc_o, alu_res_o, cnt_o, mem_rdata_o;
  logic        alu_we_o, haz_o, mem_we_o;
  logic [2:0]  alu_dst_o, mem_dst_o;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1;

  // behavioural model state
  int m_pc, m_res, m_dst, m_cnt, m_rdata, m_mdst;
  bit m_we, m_haz, m_mwe;
  int mem_m [256];

  exec_mem_unit dut (
    .clk_i(clk), .rst(rst), .alu_op_i(op), .op_a_i(a), .op_b_i(b),
    .dst_i(dst), .haz_i(hz), .cnt_i(tgt), .mem_wr_en_i(wr),
    .mem_rd_en_i(rd), .mem_addr_i(addr), .mem_wdata_i(wdata),
    .mem_dst_i(mdst), .pc_o(pc_o), .alu_res_o(alu_res_o),
    .alu_we_o(alu_we_o), .alu_dst_o(alu_dst_o), .haz_o(haz_o),
    .cnt_o(cnt_o), .mem_rdata_o(mem_rdata_o), .mem_we_o(mem_we_o),
    .mem_dst_o(mem_dst_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Advance the model by one clock using the current inputs, clock the DUT, compare.
  task automatic step();
    int ia = int'(a), ib = int'(b), sh = int'(b) % 16;
    bit arith = 1, tk = 0;
    int r = 0;
    if (rst) begin
      m_pc = 0; m_res = 0; m_we = 0; m_dst = 0; m_haz = 0; m_cnt = 0;
      m_rdata = 0; m_mwe = 0; m_mdst = 0;
      foreach (mem_m[i]) mem_m[i] = 0;
    end else begin
      m_pc = m_haz ? m_cnt : (m_pc + 1) % 65536;
      case (op)
        8'h01: r = (ia + ib) % 65536;
        8'h02: r = (ia - ib + 65536) % 65536;
        8'h03: r = ia & ib;
        8'h04: r = ia | ib;
        8'h05: r = ia ^ ib;
        8'h06: r = int'((longint'(ia) * (longint'(1) << sh)) % 65536);
        8'h07: r = ia / (1 << sh);
        8'h08: r = (sgn(ia) < sgn(ib)) ? 1 : 0;
`ifdef ALU_MULT_EN
        8'h0C: r = int'((longint'(ia) * longint'(ib)) % 65536);
`endif
        8'h09: begin arith = 0; tk = (ia == ib); end
        8'h0A: begin arith = 0; tk = (ia != ib); end
        8'h0B: begin arith = 0; tk = 1; end
        default: arith = 0;
      endcase
      m_we = arith;
      if (arith) begin m_res = r; m_dst = int'(dst); end
      m_haz = hz && tk;
      if (m_haz) m_cnt = int'(tgt);
      m_mwe = rd;
      if (rd) begin m_rdata = mem_m[addr % 256]; m_mdst = int'(mdst); end
      if (wr) mem_m[addr % 256] = int'(wdata);
    end
    @(posedge clk); #1;
    if (chk_on) begin
      chk("pc", int'(pc_o), m_pc);
      chk("alu_we", int'(alu_we_o), int'(m_we));
      chk("alu_res", int'(alu_res_o), m_res);
      chk("alu_dst", int'(alu_dst_o), m_dst);
      chk("haz", int'(haz_o), int'(m_haz));
      chk("cnt", int'(cnt_o), m_cnt);
      chk("mem_we", int'(mem_we_o), int'(m_mwe));
      chk("mem_rdata", int'(mem_rdata_o), m_rdata);
      chk("mem_dst", int'(mem_dst_o), m_mdst);
    end
  endtask

  task automatic idle();
    op = 8'h00; a = '0; b = '0; dst = '0; hz = 0; tgt = '0;
    wr = 0; rd = 0; addr = '0; wdata = '0; mdst = '0;
  endtask

  task automatic alu(input logic [7:0] o, input logic [15:0] x, input logic [15:0] y,
                     input logic [2:0] d);
    idle(); op = o; a = x; b = y; dst = d; step();
  endtask

  initial begin
    idle();
    foreach (mem_m[i]) mem_m[i] = 0;
    // reset for two cycles
    rst = 1; step(); step();
    rst = 0;
    // free-running PC
    repeat (4) step();
    // ALU boundary cases
    alu(8'h01, 16'h7FFF, 16'h0001, 3'd1); chk("add_edge", int'(alu_res_o), 16'h8000);
    alu(8'h02, 16'h0000, 16'h0001, 3'd2); chk("sub_edge", int'(alu_res_o), 16'hFFFF);
    alu(8'h08, 16'hFFFF, 16'h0001, 3'd3); chk("slt_signed", int'(alu_res_o), 1);
    alu(8'h06, 16'h0001, 16'h0004, 3'd4); chk("sll4", int'(alu_res_o), 16'h0010);
    alu(8'h07, 16'h8000, 16'h000F, 3'd5);
    alu(8'h03, 16'hF0F0, 16'h3C3C, 3'd6);
    alu(8'h04, 16'hF0F0, 16'h0F0F, 3'd7);
    alu(8'h05, 16'hFFFF, 16'h00FF, 3'd0);
    alu(8'h0C, 16'h0100, 16'h0101, 3'd2);
`ifdef ALU_MULT_EN
    chk("mul", int'(alu_res_o), 16'h0100);
`else
    chk("mul_off_we", int'(alu_we_o), 0);
`endif
    // taken BEQ with redirect
    idle(); op = 8'h09; a = 16'd5; b = 16'd5; hz = 1; tgt = 12'h040; step();
    chk("beq_haz", int'(haz_o), 1);
    chk("beq_cnt", int'(cnt_o), 16'h0040);
    idle(); step();
    chk("beq_pc", int'(pc_o), 16'h0040);
    chk("beq_pulse", int'(haz_o), 0);
    // BNE with equal operands, BEQ without haz_i
    idle(); op = 8'h0A; a = 16'd7; b = 16'd7; hz = 1; tgt = 12'h100; step();
    idle(); op = 8'h09; a = 16'd7; b = 16'd7; hz = 0; tgt = 12'h100; step();
    // back-to-back JMPs
    idle(); op = 8'h0B; hz = 1; tgt = 12'h123; step();
    idle(); op = 8'h0B; hz = 1; tgt = 12'h456; step();
    idle(); step();
    // memory: store, load, RBW collision, alias
    idle(); wr = 1; addr = 16'd3; wdata = 16'hBEEF; step();
    idle(); rd = 1; addr = 16'd3; mdst = 3'd5; step();
    chk("load", int'(mem_rdata_o), 16'hBEEF);
    idle(); rd = 1; wr = 1; addr = 16'd3; wdata = 16'h1234; mdst = 3'd6; step();
    chk("rbw_old", int'(mem_rdata_o), 16'hBEEF);
    idle(); rd = 1; addr = 16'd259; mdst = 3'd1; step();
    chk("alias", int'(mem_rdata_o), 16'h1234);
    idle(); step();
    chk("rdata_hold", int'(mem_rdata_o), 16'h1234);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      op = 8'($urandom_range(0, 15));
      a = 16'($urandom); b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      dst = 3'($urandom); hz = 1'($urandom); tgt = 12'($urandom);
      wr = 1'($urandom); rd = 1'($urandom);
      addr = 16'($urandom_range(0, 7)) + (($urandom_range(0, 1) == 1) ? 16'd256 : 16'd0);
      wdata = 16'($urandom); mdst = 3'($urandom);
      step();
    end
    // reset while a taken BEQ and a load are presented
    idle(); op = 8'h09; a = 16'd1; b = 16'd1; hz = 1; tgt = 12'h0AA;
    rd = 1; addr = 16'd3; mdst = 3'd2; rst = 1; step();
    chk("mid_rst_haz", int'(haz_o), 0);
    chk("mid_rst_mwe", int'(mem_we_o), 0);
    chk("mid_rst_pc", int'(pc_o), 0);
    rst = 0; idle(); rd = 1; addr = 16'd3; step();
    chk("mem_cleared", int'(mem_rdata_o), 0);
    // PC wrap: redirect to 0xFFF, then count up to 0xFFFF and past it
    idle(); op = 8'h0B; hz = 1; tgt = 12'hFFF; step();
    idle(); step();
    chk("pc_fff", int'(pc_o), 16'h0FFF);
    chk_on = 0;
    repeat (16'hF000) step();
    chk_on = 1;
    chk("pc_ffff", int'(pc_o), 16'hFFFF);
    step();
    chk("pc_wrap", int'(pc_o), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
